// File: rtl/chnl_pkg.sv
// Shared definitions for the host-channel packing path: clog2 helper and
// lane-index / keep-mask types for the default channel geometry.
package chnl_pkg;

  localparam int CHNL_IN_WIDTH = 32;
  localparam int CHNL_RATIO    = 4;

  // Minimum one bit so a lane index is always a legal vector.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

  typedef logic [clog2(CHNL_RATIO)-1:0] lane_idx_t;
  typedef logic [CHNL_RATIO-1:0]        keep_t;

endpackage

// File: rtl/chnl_word_packer.sv
// Packs RATIO narrow input beats into one wide entry with keep/last sideband;
// feeds the deep buffer FIFO as {o_last, o_keep, o_data}.
module chnl_word_packer
  import chnl_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_val,
  output logic                      i_rdy,
  input  logic [IN_WIDTH-1:0]       i_data,
  input  logic                      i_last,
  output logic                      o_val,
  input  logic                      o_rdy,
  output logic [IN_WIDTH*RATIO-1:0] o_data,
  output logic [RATIO-1:0]          o_keep,
  output logic                      o_last
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int LANE_W    = clog2(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  // Lanes 0..top inclusive hold real data.
  function automatic logic [RATIO-1:0] keep_mask(input logic [LANE_W-1:0] top);
    logic [RATIO-1:0] m;
    m = '0;
    for (int k = 0; k < RATIO; k++) m[k] = (LANE_W'(k) <= top);
    return m;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] lane_merge(
    input logic [OUT_WIDTH-1:0] acc,
    input logic [LANE_W-1:0]    lane,
    input logic [IN_WIDTH-1:0]  beat
  );
    logic [OUT_WIDTH-1:0] r;
    r = acc;
    for (int k = 0; k < RATIO; k++)
      if (lane == LANE_W'(k)) r[k*IN_WIDTH +: IN_WIDTH] = beat;
    return r;
  endfunction

  logic [OUT_WIDTH-1:0] acc_p0;
  logic [LANE_W-1:0]    lane_cnt_p0;
  logic [OUT_WIDTH-1:0] merged;
  logic                 cand;
  logic                 accept;
  logic                 load;

  // Stage p0: accept beat into the accumulator lane or close the entry
  assign cand   = (lane_cnt_p0 == LAST_LANE) || i_last;
  assign i_rdy  = rst_n && (!cand || !o_val || o_rdy);
  assign accept = i_val && i_rdy;
  assign load   = accept && cand;
  assign merged = lane_merge(acc_p0, lane_cnt_p0, i_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0      <= '0;
      lane_cnt_p0 <= '0;
    end else if (accept) begin
      if (cand) begin
        acc_p0      <= '0;
        lane_cnt_p0 <= '0;
      end else begin
        acc_p0      <= merged;
        lane_cnt_p0 <= lane_cnt_p0 + LANE_W'(1);
      end
    end
  end

  // Stage p1: output register; contents only change on a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_val  <= 1'b0;
      o_data <= '0;
      o_keep <= '0;
      o_last <= 1'b0;
    end else begin
      if (load) begin
        o_val  <= 1'b1;
        o_data <= merged;
        o_keep <= keep_mask(lane_cnt_p0);
        o_last <= i_last;
      end else if (o_rdy) begin
        o_val  <= 1'b0;
      end
    end
  end

endmodule
